// File: rtl/microp_button_debounce_if.sv
// Pushbutton pad and debounced outputs bundled between the pad side (master)
// and the debouncer (slave).
interface microp_button_debounce_if;
    logic btn_raw;
    logic btn_clean;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/microp_button_debounce.sv
// Active-low pushbutton debouncer: 2-flop synchronizer, 4-state qualify FSM, edge strobes.
// Define MICROP_BTN_LONGPRESS_EN to build the hold counter that drives long_press.
module microp_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    microp_button_debounce_if.slave bus
);
    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    if (DEBOUNCE_CYCLES < 2 ||
        64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2 and fit in CNT_WIDTH bits");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long_min
        $error("LONG_CYCLES must be >= 2");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clean_q, clean_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;

    always_comb begin
        s1_d      = bus.btn_raw;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            REL: begin
                if (!s2_q) begin
                    state_d = CHK_P;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_P: begin
                if (s2_q) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRS: begin
                if (s2_q) begin
                    state_d = CHK_R;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_R: begin
                if (!s2_q) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d   = REL;
                    cnt_d     = '0;
                    clean_d   = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            state_q   <= REL;
            cnt_q     <= '0;
            clean_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.btn_clean     = clean_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

`ifdef MICROP_BTN_LONGPRESS_EN
    localparam logic [CNT_WIDTH-1:0] HOLD_DONE = CNT_WIDTH'(LONG_CYCLES - 1);

    if (64'(LONG_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_long
        $error("LONG_CYCLES must fit in CNT_WIDTH bits");
    end

    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic                 long_done_q, long_done_d;
    logic                 long_q, long_d;

    // Hold count restarts on every PRS entry; long_done keeps it to one strobe per press.
    always_comb begin
        hold_d      = '0;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (state_q == PRS && state_d == PRS && hold_q != HOLD_DONE) begin
            hold_d = hold_q + CNT_ONE;
        end else if (state_q == PRS && state_d == PRS) begin
            hold_d = hold_q;
        end
        if (state_q == PRS && hold_q == HOLD_DONE && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end
        if (state_d == REL) begin
            long_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_microp_button_debounce.sv
// Directed bench for microp_button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32, CNT_WIDTH=6.
module tb_microp_button_debounce;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

`ifdef MICROP_BTN_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    microp_button_debounce_if bif ();

    microp_button_debounce #(
        .DEBOUNCE_CYCLES (8),
        .CNT_WIDTH       (6),
        .LONG_CYCLES     (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_outs(input string tag, input int k, input logic c, input logic p,
                            input logic r, input logic l);
        chk($sformatf("%s[%0d].btn_clean", tag, k), 32'(bif.btn_clean), 32'(c));
        chk($sformatf("%s[%0d].press", tag, k), 32'(bif.press_pulse), 32'(p));
        chk($sformatf("%s[%0d].release", tag, k), 32'(bif.release_pulse), 32'(r));
        chk($sformatf("%s[%0d].long", tag, k), 32'(bif.long_press), 32'(l));
    endtask

    // Advance one clock edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        bif.btn_raw = 1'b1;

        repeat (3) cyc();
        exp_outs("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.cnt", 32'(dut.cnt_q), 32'd0);
        reset_n = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp_outs("idle", k, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Press held 60 cycles: accept at edge 10, long strobe 32 edges later.
        bif.btn_raw = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            exp_outs("press", k, (k < 10), (k == 10), 1'b0, LONG_EN && (k == 42));
        end

        // Short release bounce while pressed: nothing changes.
        bif.btn_raw = 1'b1;
        repeat (5) cyc();
        bif.btn_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            exp_outs("rel_glitch", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        bif.btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp_outs("release", k, (k >= 10), 1'b0, (k == 10), 1'b0);
        end

        for (int g = 0; g < 4; g++) begin
            bif.btn_raw = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                cyc();
                exp_outs("glitch_lo", g * 10 + k, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            bif.btn_raw = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                cyc();
                exp_outs("glitch_hi", g * 10 + k, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            chk($sformatf("glitch_cnt[%0d]", g), 32'(dut.cnt_q), 32'd0);
        end

        // Longest rejected glitch: DEBOUNCE_CYCLES-1 low cycles.
        bif.btn_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            exp_outs("glitch7_lo", k, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        bif.btn_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            exp_outs("glitch7_hi", k, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("glitch7_cnt", 32'(dut.cnt_q), 32'd0);

        // Reset at count 5 of CHK_P with the button held.
        bif.btn_raw = 1'b0;
        repeat (7) cyc();
        chk("chkp_cnt5", 32'(dut.cnt_q), 32'd5);
        reset_n = 1'b0;
        repeat (2) cyc();
        exp_outs("midrst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst.cnt", 32'(dut.cnt_q), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            exp_outs("requal", k, (k < 10), (k == 10), 1'b0, 1'b0);
        end

        bif.btn_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            exp_outs("release2", k, (k >= 10), 1'b0, (k == 10), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/microp_button_debounce.md
MICROP_BUTTON_DEBOUNCE -- requirements
Module: microp_button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles a new level must be stable before acceptance (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_WIDTH, default 20, meaning stability counter width.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, meaning pressed-hold cycles for a long-press event (used only with the REQ-025 macro).
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port btn_raw, input, 1, meaning asynchronous pushbutton pad; active-low (0 = pressed).
REQ-007 SHALL have port btn_clean, output, 1, meaning debounced level in pad polarity; it drives the in_port input of the button PIO.
REQ-008 SHALL have port press_pulse, output, 1, meaning one-cycle strobe on an accepted press.
REQ-009 SHALL have port release_pulse, output, 1, meaning one-cycle strobe on an accepted release.
REQ-010 SHALL have port long_press, output, 1, meaning one-cycle strobe on a long-press event.

Function
REQ-011 SHALL pass btn_raw through a two-flop synchronizer (s1, s2); only s2 feeds the debounce logic.
REQ-012 SHALL implement FSM states REL (stable released), CHK_P (press pending), PRS (stable pressed), CHK_R (release pending).
REQ-013 REL -> CHK_P when s2 = 0; PRS -> CHK_R when s2 = 1; the counter loads 1 on entry.
REQ-014 In CHK_P/CHK_R, each cycle the differing level persists, the counter increments; a return of s2 to the stable level returns the FSM to REL/PRS and clears the counter, with no output change.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, the FSM SHALL enter PRS (from CHK_P) or REL (from CHK_R) on that edge.
REQ-016 btn_clean SHALL be registered; it goes 0 on entry to PRS and 1 on entry to REL, in the same cycle as the state change.
REQ-017 press_pulse/release_pulse SHALL be high exactly one cycle, the cycle btn_clean changes; never both high together.
REQ-018 Latency: btn_clean changes DEBOUNCE_CYCLES+2 clk edges after btn_raw settles (2 synchronizer + DEBOUNCE_CYCLES).
REQ-019 The counter SHALL saturate and never wrap; 2 <= DEBOUNCE_CYCLES < 2^CNT_WIDTH and LONG_CYCLES < 2^CNT_WIDTH' are required (simulation $error otherwise; CNT_WIDTH SHALL be sized to cover LONG_CYCLES when the macro is set).
REQ-020 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.
REQ-021 long_press SHALL stay 0 when the REQ-025 macro is undefined.

Reset
REQ-022 With reset_n = 0 at a clk edge: FSM = REL, counter = 0, s1 = s2 = 1, btn_clean = 1, all pulses 0.
REQ-023 Reset mid-debounce or mid-press SHALL abort the pending transition without emitting any pulse; after release, a held button is re-qualified from REL (full DEBOUNCE_CYCLES).
REQ-024 No output SHALL change asynchronously to clk.

Configuration
REQ-025 Macro MICROP_BTN_LONGPRESS_EN: when defined, a hold counter starts at 0 on entry to PRS, increments each PRS cycle, and long_press pulses one cycle when it reaches LONG_CYCLES-1, at most once per press; leaving PRS clears it.
REQ-026 Without MICROP_BTN_LONGPRESS_EN: no hold counter is built, long_press is tied 0, all other behaviour is identical.

Verification (DEBOUNCE_CYCLES = 8, LONG_CYCLES = 32, CNT_WIDTH = 6)
REQ-027 Reset, btn_raw = 1 for 20 cycles -> btn_clean = 1, all pulses 0 throughout.
REQ-028 btn_raw 1->0 held 30 cycles -> btn_clean = 0 exactly 10 edges after the drop; press_pulse high one cycle aligned to it.
REQ-029 btn_raw low 5 cycles then high, repeated 4 times -> no output change, counter returns to 0 each time.
REQ-030 Press accepted, then btn_raw 0->1 held 20 cycles -> btn_clean = 1 after 10 edges, release_pulse one cycle.
REQ-031 Press held 60 cycles with macro defined -> long_press one cycle, 32 cycles after press_pulse, once only; macro undefined -> long_press stays 0.
REQ-032 reset_n pulsed low at count 5 of CHK_P with btn_raw held 0 -> outputs reset values, no pulse; press_pulse appears 10 edges after reset_n rises.
